// File: rtl/rat_intr_pkg.sv
// rat_intr_pkg: types and constants shared by the RAT MCU interrupt
// sequencer and the control unit.
//   intr_state_t : sequencer FSM states
//   INTR_VECTOR  : ISR entry address used by the control unit
//   CNT_W        : width of the optional debounce counter
package rat_intr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TAKE    = 2'd1,
    ST_ISR     = 2'd2,
    ST_RESTORE = 2'd3
  } intr_state_t;

  localparam logic [9:0]  INTR_VECTOR = 10'h3FF;
  localparam int unsigned CNT_W       = 8;

endpackage

// File: rtl/intr_sync_edge.sv
// intr_sync_edge: synchronizes the asynchronous interrupt request and
// produces a registered one-cycle pulse per accepted high episode.
// Optional feature macro: INTR_DEBOUNCE_EN (debounce counter instead of a
// plain rising-edge detect).
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        synchronous active-high reset
//   i_intr_in    asynchronous interrupt request
//   o_edge_pulse one-cycle pulse per accepted request
module intr_sync_edge
  import rat_intr_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_intr_in,
  output logic o_edge_pulse
);

  // Elaboration-time parameter range checks
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("intr_sync_edge: SYNC_STAGES must be at least 2");
  end
  if ((DEBOUNCE_CYCLES < 1) || (DEBOUNCE_CYCLES > 255)) begin : g_bad_deb
    $error("intr_sync_edge: DEBOUNCE_CYCLES must be within 1..255");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic                   r_pulse;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Synchronizer chain; stage 0 samples the asynchronous pin
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_intr_in};
    end
  end

`ifdef INTR_DEBOUNCE_EN
  logic [CNT_W-1:0] r_cnt;

  // Saturating high-time counter; the pulse fires only on the transition
  // into DEBOUNCE_CYCLES, so a long episode yields a single pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      if (!w_sync) begin
        r_cnt <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_pulse <= w_sync && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    end
  end
`else
  logic r_sync_d;

  // Registered rising-edge detect on the last synchronizer stage
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync_d <= 1'b0;
      r_pulse  <= 1'b0;
    end else begin
      r_sync_d <= w_sync;
      r_pulse  <= w_sync & ~r_sync_d;
    end
  end
`endif

  assign o_edge_pulse = r_pulse;

endmodule

// File: rtl/rat_intr_ctrl.sv
// rat_intr_ctrl: RAT MCU interrupt sequencer. Holds the interrupt-enable
// flag, latches external requests, tells the control unit when to enter
// the ISR and drives the FLAGS shadow save/restore controls.
// Optional feature macro: INTR_DEBOUNCE_EN (see intr_sync_edge).
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_intr_in           asynchronous external interrupt request
//   i_instr_boundary    control unit at fetch, interrupt may be taken
//   i_i_set, i_i_clr    SEI / CLI executing
//   i_reti_req          RETIE/RETID executing (pulse)
//   i_reti_ie           1=RETIE, 0=RETID
//   o_int_take          pulse: push PC and jump to INTR_VECTOR
//   o_flg_shad_ld       FLAGS: copy C/Z into shadow
//   o_flg_ld_sel        FLAGS: shadow selected as C/Z load source
//   o_flg_restore       FLAGS: load strobe for C/Z restore
//   o_i_flag            interrupt enable
//   o_int_pending       latched, unserviced request
//   o_in_isr            ISR active
module rat_intr_ctrl
  import rat_intr_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_intr_in,
  input  logic i_instr_boundary,
  input  logic i_i_set,
  input  logic i_i_clr,
  input  logic i_reti_req,
  input  logic i_reti_ie,
  output logic o_int_take,
  output logic o_flg_shad_ld,
  output logic o_flg_ld_sel,
  output logic o_flg_restore,
  output logic o_i_flag,
  output logic o_int_pending,
  output logic o_in_isr
);

  intr_state_t r_state, w_state_nxt;
  logic        r_i_flag, w_i_flag_nxt;
  logic        r_pending, w_pending_nxt;
  logic        r_reti_ie, w_reti_ie_nxt;
  logic        r_take, r_restore, r_in_isr;
  logic        w_edge;

  intr_sync_edge #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync_edge (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_intr_in   (i_intr_in),
    .o_edge_pulse(w_edge)
  );

  // Next-state and flag update
  always_comb begin
    w_state_nxt   = r_state;
    w_i_flag_nxt  = r_i_flag;
    w_pending_nxt = r_pending;
    w_reti_ie_nxt = r_reti_ie;
    unique case (r_state)
      ST_IDLE: begin
        // Requests are only accepted while idle and enabled
        if (w_edge && r_i_flag) begin
          w_pending_nxt = 1'b1;
        end
        if (i_i_clr) begin
          w_i_flag_nxt = 1'b0;
        end else if (i_i_set) begin
          w_i_flag_nxt = 1'b1;
        end
        // A CLI in the same cycle blocks the take
        if (r_pending && r_i_flag && i_instr_boundary && !i_i_clr) begin
          w_state_nxt = ST_TAKE;
        end
      end
      ST_TAKE: begin
        w_i_flag_nxt  = 1'b0;
        w_pending_nxt = 1'b0;
        w_state_nxt   = ST_ISR;
      end
      ST_ISR: begin
        // SEI/CLI ignored here: single shadow, no nesting
        if (i_reti_req) begin
          w_reti_ie_nxt = i_reti_ie;
          w_state_nxt   = ST_RESTORE;
        end
      end
      ST_RESTORE: begin
        w_i_flag_nxt = r_reti_ie;
        w_state_nxt  = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, flags and state-decoded outputs, all registered together
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_i_flag  <= 1'b0;
      r_pending <= 1'b0;
      r_reti_ie <= 1'b0;
      r_take    <= 1'b0;
      r_restore <= 1'b0;
      r_in_isr  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_i_flag  <= w_i_flag_nxt;
      r_pending <= w_pending_nxt;
      r_reti_ie <= w_reti_ie_nxt;
      r_take    <= (w_state_nxt == ST_TAKE);
      r_restore <= (w_state_nxt == ST_RESTORE);
      r_in_isr  <= (w_state_nxt == ST_ISR) || (w_state_nxt == ST_RESTORE);
    end
  end

  assign o_int_take    = r_take;
  assign o_flg_shad_ld = r_take;
  assign o_flg_ld_sel  = r_restore;
  assign o_flg_restore = r_restore;
  assign o_i_flag      = r_i_flag;
  assign o_int_pending = r_pending;
  assign o_in_isr      = r_in_isr;

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// tb_rat_intr_ctrl: self-checking bench for rat_intr_ctrl. Directed
// scenarios plus a randomized run, all compared against a behavioural
// model that keeps the raw INTR_IN sample history and applies the
// sequencer rules to it.
module tb_rat_intr_ctrl;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;
`ifdef INTR_DEBOUNCE_EN
  localparam int unsigned WIN  = DEB;
`else
  localparam int unsigned WIN  = 1;
`endif
  // Request pulse length long enough to be accepted in either build
  localparam int HI = (WIN == 1) ? 3 : int'(WIN) + 2;

  localparam int M_IDLE    = 0;
  localparam int M_TAKE    = 1;
  localparam int M_ISR     = 2;
  localparam int M_RESTORE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, intr, bnd, iset, iclr, reti, reti_ie;
  logic take, shad, ldsel, restore, iflag, pend, inisr;
  logic [6:0] act;
  assign act = {take, shad, ldsel, restore, iflag, pend, inisr};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_mode;
  bit m_flag, m_pend, m_ie;
  bit m_hist [0:63];   // m_hist[j] = INTR_IN sampled j+1 edges ago

  rat_intr_ctrl #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_intr_in       (intr),
    .i_instr_boundary(bnd),
    .i_i_set         (iset),
    .i_i_clr         (iclr),
    .i_reti_req      (reti),
    .i_reti_ie       (reti_ie),
    .o_int_take      (take),
    .o_flg_shad_ld   (shad),
    .o_flg_ld_sel    (ldsel),
    .o_flg_restore   (restore),
    .o_i_flag        (iflag),
    .o_int_pending   (pend),
    .o_in_isr        (inisr)
  );

  // One clock edge of the reference model, using the inputs driven for it
  task automatic model_step();
    bit accept, go;
    if (rst) begin
      m_mode = M_IDLE;
      m_flag = 0;
      m_pend = 0;
      m_ie   = 0;
      foreach (m_hist[j]) m_hist[j] = 0;
    end else begin
      // A request counts when the sample SYNC+WIN edges ago was the first
      // of WIN consecutive high samples
      accept = !m_hist[SYNC+WIN];
      for (int j = SYNC; j < SYNC + WIN; j++) if (!m_hist[j]) accept = 0;
      go = 0;
      case (m_mode)
        M_IDLE: begin
          go = m_pend && m_flag && bnd && !iclr;
          if (accept && m_flag) m_pend = 1;
          if (iclr) m_flag = 0;
          else if (iset) m_flag = 1;
          if (go) m_mode = M_TAKE;
        end
        M_TAKE: begin
          m_flag = 0;
          m_pend = 0;
          m_mode = M_ISR;
        end
        M_ISR: begin
          if (reti) begin
            m_ie   = reti_ie;
            m_mode = M_RESTORE;
          end
        end
        default: begin
          m_flag = m_ie;
          m_mode = M_IDLE;
        end
      endcase
      for (int j = 63; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = intr;
    end
  endtask

  function automatic logic [6:0] exp_vec();
    return {m_mode == M_TAKE, m_mode == M_TAKE, m_mode == M_RESTORE,
            m_mode == M_RESTORE, logic'(m_flag), logic'(m_pend),
            (m_mode == M_ISR) || (m_mode == M_RESTORE)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    intr = 0; bnd = 0; iset = 0; iclr = 0; reti = 0; reti_ie = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    tick();
    tick();
    n_tests++;
    if (act !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected %b", act, 7'b0);
    end
    rst = 0;
    tick();
    n_tests++;
    if (act !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected %b", act, exp_vec());
    end
  endtask

  task automatic test_basic_take();
    int pend_at = -1;
    int takes = 0;
    int shads = 0;
    bnd = 1;
    for (int c = 0; c < 16; c++) begin
      iset = (c == 0);
      intr = (c >= 1) && (c <= HI);
      tick();
      n_tests++;
      if (act !== exp_vec()) begin
        n_fail++;
        $display("FAIL basic_take c=%0d: got %b expected %b", c, act, exp_vec());
      end
      if (pend && pend_at < 0) pend_at = c;
      takes += int'(take);
      shads += int'(shad);
    end
    intr = 0;
    iset = 0;
    n_tests++;
    if (pend_at != 1 + int'(SYNC) + int'(WIN)) begin
      n_fail++;
      $display("FAIL pending_latency: got edge %0d expected edge %0d", pend_at, 1 + SYNC + WIN);
    end
    n_tests++;
    if (takes != 1 || shads != 1) begin
      n_fail++;
      $display("FAIL take_pulse_len: got take=%0d shad=%0d cycles expected 1/1", takes, shads);
    end
    n_tests++;
    if ({iflag, inisr} !== 2'b01) begin
      n_fail++;
      $display("FAIL after_take: got iflag=%b inisr=%b expected 0/1", iflag, inisr);
    end
  endtask

  task automatic test_reti(input bit ie);
    reti = 1;
    reti_ie = ie;
    tick();
    reti = 0;
    n_tests++;
    if (act !== exp_vec()) begin
      n_fail++;
      $display("FAIL reti_model ie=%0d: got %b expected %b", ie, act, exp_vec());
    end
    n_tests++;
    if ({ldsel, restore, inisr} !== 3'b111) begin
      n_fail++;
      $display("FAIL reti_strobes ie=%0d: got ldsel/restore/inisr=%b%b%b expected 111",
               ie, ldsel, restore, inisr);
    end
    tick();
    n_tests++;
    if ({iflag, inisr, ldsel, restore} !== {logic'(ie), 3'b000}) begin
      n_fail++;
      $display("FAIL reti_exit ie=%0d: got iflag/inisr/ldsel/restore=%b%b%b%b expected %b000",
               ie, iflag, inisr, ldsel, restore, ie);
    end
  endtask

  task automatic test_reentry();
    bit got = 0;
    bnd = 1;
    for (int c = 0; c < 48 && !got; c++) begin
      intr = (c >= 2) && (c < 2 + HI);
      tick();
      n_tests++;
      if (act !== exp_vec()) begin
        n_fail++;
        $display("FAIL reentry c=%0d: got %b expected %b", c, act, exp_vec());
      end
      if (inisr === 1'b1) got = 1;
    end
    intr = 0;
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL reentry_timeout: got in_isr=%b expected 1 within 48 cycles", inisr);
    end
  endtask

  task automatic test_masked();
    int takes = 0;
    int pends = 0;
    bnd = 1;
    for (int c = 0; c < 34; c++) begin
      iclr = (c == 0);
      iset = (c == 20);
      intr = (c >= 2) && (c < 2 + HI);
      tick();
      n_tests++;
      if (act !== exp_vec()) begin
        n_fail++;
        $display("FAIL masked c=%0d: got %b expected %b", c, act, exp_vec());
      end
      takes += int'(take);
      pends += int'(pend);
    end
    iclr = 0;
    iset = 0;
    intr = 0;
    n_tests++;
    if (takes != 0 || pends != 0 || iflag !== 1'b1) begin
      n_fail++;
      $display("FAIL masked_discard: got takes=%0d pend_cycles=%0d iflag=%b expected 0/0/1",
               takes, pends, iflag);
    end
  endtask

  task automatic test_boundary_hold();
    int takes = 0;
    // Pending held while the control unit is never at a boundary
    bnd = 0;
    for (int c = 0; c < 1 + int'(SYNC) + int'(WIN) + 11; c++) begin
      iset = (c == 0);
      intr = (c >= 1) && (c <= HI);
      tick();
      n_tests++;
      if (act !== exp_vec()) begin
        n_fail++;
        $display("FAIL hold c=%0d: got %b expected %b", c, act, exp_vec());
      end
      takes += int'(take);
    end
    iset = 0;
    intr = 0;
    n_tests++;
    if (takes != 0 || pend !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_no_take: got takes=%0d pend=%b expected 0/1", takes, pend);
    end
    bnd = 1;
    tick();
    n_tests++;
    if (take !== 1'b1 || act !== exp_vec()) begin
      n_fail++;
      $display("FAIL boundary_take: got %b expected %b", act, exp_vec());
    end
    tick();
    reti = 1;
    reti_ie = 1;
    tick();
    reti = 0;
    tick();
    n_tests++;
    if (act !== exp_vec()) begin
      n_fail++;
      $display("FAIL hold_return: got %b expected %b", act, exp_vec());
    end
    // Fresh request with boundary held low, then SEI+CLI together
    bnd = 0;
    for (int c = 0; c < 1 + int'(SYNC) + int'(WIN) + 2; c++) begin
      intr = (c < HI);
      tick();
    end
    intr = 0;
    n_tests++;
    if (pend !== 1'b1 || act !== exp_vec()) begin
      n_fail++;
      $display("FAIL setclr_pre: got %b expected %b", act, exp_vec());
    end
    bnd = 1;
    iset = 1;
    iclr = 1;
    tick();
    iset = 0;
    iclr = 0;
    n_tests++;
    if ({take, iflag} !== 2'b00 || act !== exp_vec()) begin
      n_fail++;
      $display("FAIL setclr_both: got %b expected %b", act, exp_vec());
    end
    takes = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      takes += int'(take);
    end
    n_tests++;
    if (takes != 0 || pend !== 1'b1) begin
      n_fail++;
      $display("FAIL setclr_hold: got takes=%0d pend=%b expected 0/1", takes, pend);
    end
    iset = 1;
    tick();
    iset = 0;
    tick();
    n_tests++;
    if (take !== 1'b1 || act !== exp_vec()) begin
      n_fail++;
      $display("FAIL late_sei_take: got %b expected %b", act, exp_vec());
    end
    tick();
  endtask

  task automatic test_reset_in_isr();
    n_tests++;
    if (inisr !== 1'b1) begin
      n_fail++;
      $display("FAIL isr_precondition: got in_isr=%b expected 1", inisr);
    end
    rst = 1;
    tick();
    rst = 0;
    n_tests++;
    if (act !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_in_isr: got %b expected %b", act, 7'b0);
    end
    reti = 1;
    reti_ie = 1;
    tick();
    reti = 0;
    n_tests++;
    if ({ldsel, restore, iflag, inisr} !== 4'b0000 || act !== exp_vec()) begin
      n_fail++;
      $display("FAIL reti_after_reset: got %b expected %b", act, exp_vec());
    end
    tick();
    n_tests++;
    if (act !== 7'b0) begin
      n_fail++;
      $display("FAIL reti_after_reset_2: got %b expected %b", act, 7'b0);
    end
  endtask

`ifdef INTR_DEBOUNCE_EN
  task automatic test_debounce();
    int pends = 0;
    int rises = 0;
    int first = -1;
    logic prev;
    rst = 1;
    idle_inputs();
    tick();
    rst = 0;
    // Short glitch: never reaches the count
    for (int c = 0; c < 20; c++) begin
      iset = (c == 0);
      intr = (c >= 1) && (c <= 3);
      tick();
      pends += int'(pend);
    end
    iset = 0;
    n_tests++;
    if (pends != 0) begin
      n_fail++;
      $display("FAIL debounce_short: got %0d pending cycles expected 0", pends);
    end
    prev = pend;
    for (int c = 0; c < 16; c++) begin
      intr = (c >= 1) && (c <= 6);
      tick();
      n_tests++;
      if (act !== exp_vec()) begin
        n_fail++;
        $display("FAIL debounce_model c=%0d: got %b expected %b", c, act, exp_vec());
      end
      if (pend && !prev) begin
        rises++;
        if (first < 0) first = c;
      end
      prev = pend;
    end
    intr = 0;
    n_tests++;
    if (rises != 1 || first != 1 + int'(SYNC) + int'(DEB)) begin
      n_fail++;
      $display("FAIL debounce_long: got %0d rises first at %0d expected 1 at %0d",
               rises, first, 1 + SYNC + DEB);
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 5) == 0) intr = ~intr;
      bnd     = ($urandom_range(0, 3) != 0);
      iset    = ($urandom_range(0, 7) == 0);
      iclr    = ($urandom_range(0, 15) == 0);
      reti    = ($urandom_range(0, 5) == 0);
      reti_ie = 1'($urandom_range(0, 1));
      tick();
      n_tests++;
      if (act !== exp_vec()) begin
        n_fail++;
        $display("FAIL random c=%0d: got %b expected %b", c, act, exp_vec());
      end
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    idle_inputs();
    m_mode = M_IDLE;
    m_flag = 0;
    m_pend = 0;
    m_ie   = 0;
    foreach (m_hist[j]) m_hist[j] = 0;
    test_reset();
    test_basic_take();
    test_reti(1'b1);
    test_reentry();
    test_reti(1'b0);
    test_masked();
    test_boundary_hold();
    test_reset_in_isr();
`ifdef INTR_DEBOUNCE_EN
    test_debounce();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
